// File: rtl/ccl_arbiter.sv
// Round-robin arbiter and init sequencer sharing one CCLU loop-stack unit among
// NUM_REQ requesters, with an ownership lock for whole nested-loop sequences.
module ccl_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_lock,
   input  logic [2*NUM_REQ-1:0]    req_cmd,
   input  logic [32*NUM_REQ-1:0]   req_address,
   input  logic [32*NUM_REQ-1:0]   req_counter,
   input  logic [32*NUM_REQ-1:0]   req_target,
   input  logic                    flush,
   output logic [NUM_REQ-1:0]      done,
   output logic [31:0]             rsp_target,
   output logic                    rsp_valid,
   output logic                    rsp_full,
   output logic                    rsp_error,
   output logic                    busy,
   output logic [ID_W-1:0]         owner,
   output logic                    locked,
   output logic [1:0]              cclu_command,
   output logic [31:0]             cclu_address,
   output logic [31:0]             cclu_counter,
   output logic [31:0]             cclu_target,
   output logic                    cclu_reset,
   input  logic [31:0]             cclu_outTarget,
   input  logic                    cclu_valid,
   input  logic                    cclu_full,
   input  logic                    cclu_error
);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      ISSUE,
      SETTLE,
      CAPTURE,
      REJECT
   } stateT;

   stateT           state;
   logic [ID_W-1:0] rrPtr;
   logic [ID_W-1:0] grantReg;
   logic [1:0]      cmdReg;
   logic            grantFound;
   logic [ID_W-1:0] grantIdx;
   logic [ID_W-1:0] candIdx;
   logic [1:0]      grantCmd;

   // A held lock makes the owner the only eligible requester; otherwise search
   // upward from the last grant with wrap so every requester gets a turn.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      candIdx    = rrPtr;
      if (locked) begin
         grantFound = req[owner];
         grantIdx   = owner;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = (candIdx == ID_W'(NUM_REQ - 1)) ? '0 : candIdx + ID_W'(1);
            if (!grantFound && req[candIdx]) begin
               grantFound = 1'b1;
               grantIdx   = candIdx;
            end
         end
      end
   end

   assign grantCmd = req_cmd[{grantIdx, 1'b0} +: 2];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= INIT;
         cclu_reset   <= 1'b1;
         cclu_command <= 2'b00;
         cclu_address <= '0;
         cclu_counter <= '0;
         cclu_target  <= '0;
         done         <= '0;
         rsp_target   <= '0;
         rsp_valid    <= 1'b0;
         rsp_full     <= 1'b0;
         rsp_error    <= 1'b0;
         locked       <= 1'b0;
         owner        <= '0;
         rrPtr        <= ID_W'(NUM_REQ - 1);
         busy         <= 1'b1;
         grantReg     <= '0;
         cmdReg       <= 2'b00;
      end else begin
         done <= '0;
         case (state)
            INIT: begin
               cclu_reset   <= 1'b0;
               cclu_command <= 2'b00;
               locked       <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            IDLE: begin
               if (flush) begin
                  cclu_reset <= 1'b1;
                  busy       <= 1'b1;
                  state      <= INIT;
               end else if (grantFound) begin
                  rrPtr    <= grantIdx;
                  grantReg <= grantIdx;
                  cmdReg   <= grantCmd;
                  busy     <= 1'b1;
                  if (grantCmd == 2'b01 || grantCmd == 2'b10) begin
                     cclu_address <= req_address[{grantIdx, 5'b00000} +: 32];
                     cclu_counter <= req_counter[{grantIdx, 5'b00000} +: 32];
                     cclu_target  <= req_target[{grantIdx, 5'b00000} +: 32];
                     state        <= ISSUE;
                  end else begin
                     state <= REJECT;
                  end
               end
            end
            ISSUE: begin
               cclu_command <= cmdReg;
               state        <= SETTLE;
            end
            // The CCLU samples the command at this edge; its result is ready one cycle later.
            SETTLE: begin
               cclu_command <= 2'b00;
               state        <= CAPTURE;
            end
            CAPTURE: begin
               rsp_target     <= cclu_outTarget;
               rsp_valid      <= cclu_valid;
               rsp_full       <= cclu_full;
               rsp_error      <= cclu_error;
               done[grantReg] <= 1'b1;
               locked         <= req_lock[grantReg];
               owner          <= grantReg;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            REJECT: begin
               rsp_target     <= '0;
               rsp_valid      <= 1'b0;
               rsp_full       <= 1'b0;
               rsp_error      <= (cmdReg == 2'b11);
               done[grantReg] <= 1'b1;
               locked         <= req_lock[grantReg];
               owner          <= grantReg;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: begin
               cclu_reset   <= 1'b1;
               cclu_command <= 2'b00;
               busy         <= 1'b1;
               state        <= INIT;
            end
         endcase
      end
   end

endmodule
